// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_program_loader
// Description : Boot-time loader for the instruction memory of the 8-bit
//               single-cycle core. Takes a byte stream over valid/ready:
//               one count byte (0 means 256) followed by high/low byte pairs.
//               Each pair is written as one 16-bit word at consecutive
//               addresses from 0. The core is held frozen until the image
//               is complete.
//               Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
//               When it is defined, one trailing byte must equal the XOR of
//               all data bytes, or the load ends in the error state.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_program_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Remaining-word counter must hold DEPTH itself (a count byte of 0).
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_ERR   = 3'd6;
    localparam logic [2:0] S_CHK   = 3'd7;
`endif

    logic [2:0]        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [7:0]        hi_q,     hi_d;
    logic [7:0]        lo_q,     lo_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        ck_q,     ck_d;
`endif

    logic              xfer;
    logic [CNT_W-1:0]  count_decoded;

    // Byte acceptance is a pure function of the state so sources see a stable ready.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_COUNT, S_HI, S_LO: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:               in_ready = 1'b1;
`endif
            default:             in_ready = 1'b0;
        endcase
    end

    assign xfer = in_valid & in_ready;

    // A count byte of zero stands for a full memory image.
    assign count_decoded = (in_byte == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(in_byte);

    // Registered-state outputs; imem_addr keeps its value between writes.
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = {hi_q, lo_q};
    assign done       = (state_q == S_DONE);
    assign cpu_hold   = (state_q != S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err        = (state_q == S_ERR);
`else
    assign err        = 1'b0;
`endif

    // Next-state and datapath update for the load sequence.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        remain_d = remain_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ck_d     = ck_q;
`endif
        case (state_q)
            // IDLE, DONE and ERR all restart a fresh load on start.
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_COUNT;
                    addr_d   = '0;
                    remain_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    ck_d     = 8'd0;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_ERR: begin
                if (start) begin
                    state_d  = S_COUNT;
                    addr_d   = '0;
                    remain_d = '0;
                    ck_d     = 8'd0;
                end
            end
`endif
            S_COUNT: begin
                if (xfer) begin
                    remain_d = count_decoded;
                    state_d  = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = in_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    ck_d    = ck_q ^ in_byte;
`endif
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = in_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    ck_d    = ck_q ^ in_byte;
`endif
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address wraps naturally at DEPTH since DEPTH == 2**ADDR_W.
                addr_d   = addr_q + ADDR_W'(1);
                remain_d = remain_q - CNT_W'(1);
                if (remain_q == CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_d = (in_byte == ck_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            hi_q     <= 8'd0;
            lo_q     <= 8'd0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            remain_q <= remain_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of the data bytes of the current image.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ck_q <= 8'd0;
        end else begin
            ck_q <= ck_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Boot-time loader sitting directly upstream of the instruction memory of the 8-bit single-cycle core.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first.
- Writes each word into instruction memory at consecutive addresses from 0.
- Holds the core (PC register and register-file writes) frozen until the image is fully loaded.

Parameters:
- ADDR_W, 8, instruction memory address width; PC width.
- DEPTH, 256, instruction memory words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte available on in_byte.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader accepts the byte this cycle; a transfer happens when in_valid & in_ready.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  16  instruction word, {hi_byte, lo_byte}.
- cpu_hold  output  1  1 = core frozen; PC mux and register-file write enables are gated by this.
- done  output  1  image loaded; level signal.
- err  output  1  load failed; sticky level signal.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State becomes IDLE.
  - Outputs: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0.
  - Reset mid-load aborts the load at once; words already written stay in memory.
- IDLE:
  - in_ready=0, cpu_hold=1.
  - start -> COUNT. Clears the word counter, address and err.
- COUNT:
  - in_ready=1.
  - On transfer: word count N = in_byte, where 0 means 256. Next state HI.
- HI:
  - in_ready=1.
  - On transfer: latch the high byte. Next state LO.
- LO:
  - in_ready=1.
  - On transfer: latch the low byte. Next state WRITE.
- WRITE (exactly 1 cycle):
  - in_ready=0, imem_we=1, imem_wdata={hi,lo}, imem_addr=current address.
  - Then address += 1 (wraps mod DEPTH) and remaining count -= 1.
  - If remaining becomes 0: next state is CHK when CHECKSUM_EN is defined, otherwise DONE. Else next state HI.
- DONE:
  - done=1, cpu_hold=0, in_ready=0.
  - start -> COUNT: cpu_hold returns to 1 on the next cycle and done drops to 0.
- ERR:
  - err=1, cpu_hold=1, in_ready=0.
  - Only start or reset leaves this state.
- imem_we is never asserted outside WRITE. imem_addr holds its value between writes.
- Bytes presented while in_ready=0 are not consumed and the source must hold them. in_valid may toggle freely; no timeout.
- start while in COUNT, HI, LO, WRITE or CHK is ignored.
- Throughput: at most one word every 3 cycles with continuous in_valid.
- First word is written at address 0. Last word of a 256-word image is written at address 255; the address then wraps to 0, which is harmless.
- Core contract: while cpu_hold=1 the PC is held at 0. The first fetch after done rises is address 0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every hi and lo data byte (excluding the count byte) is kept.
  - After the last WRITE the FSM enters CHK with in_ready=1.
  - Next transferred byte equals the XOR -> DONE. Any other value -> ERR (err=1, cpu_hold stays 1).
- Undefined:
  - No CHK state and no XOR register; err is tied 0.
  - The FSM goes WRITE -> DONE.

Test Plan:
- Reset then idle 5 cycles -> cpu_hold=1, done=0, in_ready=0, imem_we=0 every cycle.
- start, then stream 02,12,34,AB,CD with in_valid held 1 (checksum off) -> writes mem[0]=1234 and mem[1]=ABCD, one imem_we pulse each, 3 cycles apart; done=1 and cpu_hold=0 the cycle after the second WRITE.
- Same stream with in_valid dropped for 4 cycles between AB and CD -> same memory contents; no extra imem_we; in_ready behaves correctly throughout.
- Checksum on: 01,0F,F0 then FF -> DONE. Repeat with trailing 00 -> err=1, cpu_hold=1, done=0; a later start clears err.
- Count byte 00 followed by 512 bytes -> 256 writes covering addresses 0..255 in order, then done=1.
- Assert rst_n=0 after the HI byte of word 3 -> next cycle IDLE with all outputs at reset values; no write of a partial word.
